// File: rtl/lc3b_pkg.sv
// Shared types and helpers for the LC-3b memory controller.
package lc3b_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_e;

  localparam int MEM_CYCLES_DEFAULT = 5;

  // Byte writes replicate the low byte so either SRAM lane can take it.
  function automatic logic [15:0] fmt_wdata(input logic word, input logic [15:0] mdr);
    if (word) begin
      return mdr;
    end else begin
      return {mdr[7:0], mdr[7:0]};
    end
  endfunction

  function automatic logic [1:0] lane_we(input logic word, input logic a0);
    if (word) begin
      return 2'b11;
    end else if (a0) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/lc3b_wait_counter.sv
// 4-bit load/decrement counter timing the SRAM access window.
module lc3b_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic [3:0] count_q,
  output logic [3:0] count_d
);

  // Next count: load wins over decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec) begin
      count_d = count_q - 4'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lc3b_memory_ctrl.sv
// LC-3b memory controller: captures a request, waits MEM_CYCLES, then
// pulses R; drives a single-cycle SRAM strobe just before READY.
module lc3b_memory_ctrl
  import lc3b_pkg::*;
#(
  parameter int MEM_CYCLES = MEM_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic        DATA_SIZE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  output logic        R,
  output logic [15:0] MEM_DATA,
  output logic        UNALIGNED,
  output logic        mem_en,
  output logic [1:0]  mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam logic [3:0] LOAD_VAL = 4'(MEM_CYCLES - 1);

  state_e      state_q, state_d;
  logic        rw_q, rw_d, size_q, size_d;
  logic [15:0] mar_q, mar_d, wdata_q, wdata_d, mem_data_q, mem_data_d;
  logic        r_q, r_d, unaligned_q, unaligned_d, mem_en_q, mem_en_d;
  logic [1:0]  mem_we_q, mem_we_d;
  logic        load_s, dec_s, misalign_s, strobe_s;
  logic [3:0]  count_q, count_d;

  lc3b_wait_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .dec      (dec_s),
    .load_val (LOAD_VAL),
    .count_q  (count_q),
    .count_d  (count_d)
  );

  // State transitions, request capture and read-data latch.
  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    size_d     = size_q;
    mar_d      = mar_q;
    wdata_d    = wdata_q;
    mem_data_d = mem_data_q;
    load_s     = 1'b0;
    dec_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (MIO_EN) begin
          state_d = WAIT;
          rw_d    = R_W;
          size_d  = DATA_SIZE;
          mar_d   = MAR;
          wdata_d = fmt_wdata(DATA_SIZE, MDR);
          load_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        dec_s = 1'b1;
        if (count_q == 4'd1) begin
          state_d = READY;
          if (!rw_q && !(size_q && mar_q[0])) begin
            mem_data_d = mem_rdata;
          end else begin
            mem_data_d = mem_data_q;
          end
        end else begin
          state_d = WAIT;
        end
      end
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from next state so they come straight off flops.
  always_comb begin
    misalign_s = size_d & mar_d[0];
    strobe_s   = (state_d == WAIT) && (count_d == 4'd1) && !misalign_s;
    mem_en_d   = strobe_s;
    if (strobe_s && rw_d) begin
      mem_we_d = lane_we(size_d, mar_d[0]);
    end else begin
      mem_we_d = 2'b00;
    end
    r_d         = (state_d == READY);
    unaligned_d = r_d && misalign_s;
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      size_q      <= 1'b0;
      mar_q       <= 16'h0000;
      wdata_q     <= 16'h0000;
      mem_data_q  <= 16'h0000;
      r_q         <= 1'b0;
      unaligned_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      size_q      <= size_d;
      mar_q       <= mar_d;
      wdata_q     <= wdata_d;
      mem_data_q  <= mem_data_d;
      r_q         <= r_d;
      unaligned_q <= unaligned_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign R         = r_q;
  assign UNALIGNED = unaligned_q;
  assign MEM_DATA  = mem_data_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mar_q[15:1];
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lc3b_memory_ctrl.sv
// Randomised and directed bench for lc3b_memory_ctrl at MEM_CYCLES 5 and 2,
// checked every cycle against an access-timeline model.
module tb_lc3b_memory_ctrl;

  logic        clk, rst, mio_en, r_w, data_size;
  logic [15:0] mar, mdr, mem_rdata;

  logic        o1_r, o1_un, o1_en, o2_r, o2_un, o2_en;
  logic [15:0] o1_md, o1_wd, o2_md, o2_wd;
  logic [1:0]  o1_we, o2_we;
  logic [14:0] o1_ad, o2_ad;

  int n_cmp = 0;
  int n_bad = 0;

  lc3b_memory_ctrl #(.MEM_CYCLES(5)) dut1 (
    .clk(clk), .rst(rst), .MIO_EN(mio_en), .R_W(r_w), .DATA_SIZE(data_size),
    .MAR(mar), .MDR(mdr), .R(o1_r), .MEM_DATA(o1_md), .UNALIGNED(o1_un),
    .mem_en(o1_en), .mem_we(o1_we), .mem_addr(o1_ad), .mem_wdata(o1_wd),
    .mem_rdata(mem_rdata)
  );

  lc3b_memory_ctrl #(.MEM_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .MIO_EN(mio_en), .R_W(r_w), .DATA_SIZE(data_size),
    .MAR(mar), .MDR(mdr), .R(o2_r), .MEM_DATA(o2_md), .UNALIGNED(o2_un),
    .mem_en(o2_en), .mem_we(o2_we), .mem_addr(o2_ad), .mem_wdata(o2_wd),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: k counts cycles since the accepting edge (cycle 1 is first).
  typedef struct {
    bit          act;
    int          k;
    logic        rw;
    logic        sz;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] md;
  } mst_t;

  function automatic mst_t mreset();
    mst_t z;
    z.act = 1'b0; z.k = 0; z.rw = 1'b0; z.sz = 1'b0;
    z.mar = 16'h0000; z.mdr = 16'h0000; z.md = 16'h0000;
    return z;
  endfunction

  function automatic mst_t mstep(input mst_t s, input int mc, input logic mio, input logic rw,
                                 input logic sz, input logic [15:0] a, input logic [15:0] d,
                                 input logic [15:0] rd);
    mst_t n;
    n = s;
    if (s.act) begin
      if (s.k >= mc) begin
        n.act = 1'b0;
      end else begin
        if (s.k == mc - 1 && !s.rw && !(s.sz && s.mar[0])) n.md = rd;
        n.k = s.k + 1;
      end
    end else if (mio) begin
      n.act = 1'b1; n.k = 1; n.rw = rw; n.sz = sz; n.mar = a; n.mdr = d;
    end
    return n;
  endfunction

  mst_t m1 = mreset();
  mst_t m2 = mreset();

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1 <= mreset();
      m2 <= mreset();
    end else begin
      m1 <= mstep(m1, 5, mio_en, r_w, data_size, mar, mdr, mem_rdata);
      m2 <= mstep(m2, 2, mio_en, r_w, data_size, mar, mdr, mem_rdata);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input mst_t s, input int mc, input string tag, input logic r,
                         input logic [15:0] md, input logic un, input logic en,
                         input logic [1:0] we, input logic [14:0] ad, input logic [15:0] wd);
    logic mis, e_r, e_en;
    logic [1:0] e_we;
    mis  = s.sz && s.mar[0];
    e_r  = s.act && (s.k == mc);
    e_en = s.act && (s.k == mc - 1) && !mis;
    if (e_en && s.rw) e_we = s.sz ? 2'b11 : (s.mar[0] ? 2'b10 : 2'b01);
    else              e_we = 2'b00;
    chk({tag, ".R"},         16'(r),  16'(e_r));
    chk({tag, ".UNALIGNED"}, 16'(un), 16'(e_r && mis));
    chk({tag, ".mem_en"},    16'(en), 16'(e_en));
    chk({tag, ".mem_we"},    16'(we), 16'(e_we));
    chk({tag, ".mem_addr"},  16'(ad), 16'(s.mar[15:1]));
    chk({tag, ".mem_wdata"}, wd, s.sz ? s.mdr : {s.mdr[7:0], s.mdr[7:0]});
    chk({tag, ".MEM_DATA"},  md, s.md);
  endtask

  always @(negedge clk) begin
    cmp_all(m1, 5, "d5", o1_r, o1_md, o1_un, o1_en, o1_we, o1_ad, o1_wd);
    cmp_all(m2, 2, "d2", o2_r, o2_md, o2_un, o2_en, o2_we, o2_ad, o2_wd);
  end

  logic        h1_r[1:16], h1_en[1:16], h1_un[1:16], h2_r[1:16], h2_en[1:16];
  logic [1:0]  h1_we[1:16];
  logic [15:0] h1_md[1:16], h1_wd[1:16], h2_md[1:16];
  logic [14:0] h1_ad[1:16];

  // Issue one access, then record per-cycle outputs of both instances.
  task automatic run_dir(input logic rw, input logic sz, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] rdv,
                         input int ncyc, input logic hold);
    mio_en = 1'b1; r_w = rw; data_size = sz; mar = a; mdr = d;
    mem_rdata = 16'($urandom);
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      h1_r[c] = o1_r; h1_en[c] = o1_en; h1_un[c] = o1_un; h1_we[c] = o1_we;
      h1_md[c] = o1_md; h1_wd[c] = o1_wd; h1_ad[c] = o1_ad;
      h2_r[c] = o2_r; h2_en[c] = o2_en; h2_md[c] = o2_md;
      mio_en = hold;
      if (!hold) begin
        r_w = 1'($urandom); data_size = 1'($urandom);
        mar = 16'($urandom); mdr = 16'($urandom);
      end
      mem_rdata = (c == 1 || c == 4) ? rdv : 16'($urandom);
    end
  endtask

  initial begin
    rst = 1'b0; mio_en = 1'b0; r_w = 1'b0; data_size = 1'b0;
    mar = 16'h0000; mdr = 16'h0000; mem_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst.R", 16'(o1_r), 16'h0000);
    chk("rst.MEM_DATA", o1_md, 16'h0000);
    chk("rst.mem_en", 16'(o1_en), 16'h0000);
    chk("rst.mem_we", 16'(o1_we), 16'h0000);
    chk("rst.mem_addr", 16'(o1_ad), 16'h0000);
    rst = 1'b1;

    // Word read at 0x3000, accepted at the first edge after reset release
    run_dir(1'b0, 1'b1, 16'h3000, 16'h0000, 16'hBEEF, 6, 1'b0);
    chk("rd.en_c3", 16'(h1_en[3]), 16'h0000);
    chk("rd.en_c4", 16'(h1_en[4]), 16'h0001);
    chk("rd.we_c4", 16'(h1_we[4]), 16'h0000);
    chk("rd.R_c4", 16'(h1_r[4]), 16'h0000);
    chk("rd.R_c5", 16'(h1_r[5]), 16'h0001);
    chk("rd.R_c6", 16'(h1_r[6]), 16'h0000);
    chk("rd.data_c5", h1_md[5], 16'hBEEF);
    chk("rd2.en_c1", 16'(h2_en[1]), 16'h0001);
    chk("rd2.R_c1", 16'(h2_r[1]), 16'h0000);
    chk("rd2.R_c2", 16'(h2_r[2]), 16'h0001);
    chk("rd2.data_c2", h2_md[2], 16'hBEEF);

    // Byte write to the high lane
    run_dir(1'b1, 1'b0, 16'h3001, 16'h00A5, 16'h0000, 6, 1'b0);
    chk("bw.we_c4", 16'(h1_we[4]), 16'h0002);
    chk("bw.wdata_c4", h1_wd[4], 16'hA5A5);
    chk("bw.addr_c4", 16'(h1_ad[4]), 16'h1800);
    chk("bw.R_c5", 16'(h1_r[5]), 16'h0001);
    chk("bw.data_kept", h1_md[5], 16'hBEEF);

    // Unaligned word write
    run_dir(1'b1, 1'b1, 16'h4003, 16'h1234, 16'h0000, 6, 1'b0);
    for (int c = 1; c <= 6; c++) chk("uw.en_never", 16'(h1_en[c]), 16'h0000);
    chk("uw.un_c4", 16'(h1_un[4]), 16'h0000);
    chk("uw.un_c5", 16'(h1_un[5]), 16'h0001);
    chk("uw.R_c5", 16'(h1_r[5]), 16'h0001);
    chk("uw.data_kept", h1_md[5], 16'hBEEF);

    // MIO_EN held high: back-to-back reads with one idle cycle between
    run_dir(1'b0, 1'b1, 16'h0200, 16'h0000, 16'h5555, 12, 1'b1);
    chk("b2b.R_c5", 16'(h1_r[5]), 16'h0001);
    chk("b2b.R_c6", 16'(h1_r[6]), 16'h0000);
    chk("b2b.R_c10", 16'(h1_r[10]), 16'h0000);
    chk("b2b.R_c11", 16'(h1_r[11]), 16'h0001);
    chk("b2b.R_c12", 16'(h1_r[12]), 16'h0000);
    @(negedge clk);
    mio_en = 1'b0;
    repeat (7) @(negedge clk);

    // Reset in cycle 3 of a word write
    mio_en = 1'b1; r_w = 1'b1; data_size = 1'b1; mar = 16'h2000; mdr = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    mio_en = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("ra.R", 16'(o1_r), 16'h0000);
    chk("ra.mem_en", 16'(o1_en), 16'h0000);
    chk("ra.mem_we", 16'(o1_we), 16'h0000);
    chk("ra.mem_addr", 16'(o1_ad), 16'h0000);
    chk("ra.mem_wdata", o1_wd, 16'h0000);
    chk("ra.MEM_DATA", o1_md, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    run_dir(1'b0, 1'b1, 16'h0100, 16'h0000, 16'h0F0F, 6, 1'b0);
    chk("ra.next_en_c4", 16'(h1_en[4]), 16'h0001);
    chk("ra.next_R_c5", 16'(h1_r[5]), 16'h0001);
    chk("ra.next_data", h1_md[5], 16'h0F0F);

    // Random traffic with occasional short reset pulses
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      mio_en = ($urandom_range(0, 3) != 0);
      r_w = 1'($urandom); data_size = 1'($urandom);
      mar = 16'($urandom); mdr = 16'($urandom); mem_rdata = 16'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
